psram_arbiter: RTL and testbench



---
 rtl/psram_arb_pkg.sv | 19 +
 rtl/psram_arbiter_rr_pick.sv | 35 +++
 rtl/psram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_psram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arb_pkg.sv
// Shared types and sizing helpers for the PSRAM port arbiter.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWdata,
    StRdwait,
    StGap
  } state_e;

  localparam logic MEM_CMD_RD = 1'b0;
  localparam logic MEM_CMD_WR = 1'b1;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psram_arbiter_rr_pick.sv
// One-hot picker: requester 0 always wins, else round-robin over 1..NREQ-1 from ptr_i.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
    // First pass covers ptr..NREQ-1, second pass wraps to 1..ptr-1.
    for (int i = 1; i < int'(NREQ); i++) begin
      if (!found && req_i[i] && i >= int'(ptr_i)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 1; i < int'(NREQ); i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates NREQ requesters onto one PSRAM controller port and sequences each burst.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned AW         = 21,
  parameter int unsigned DW         = 32,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned GAP        = 4,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      we_i,
  input  logic [NREQ*AW-1:0]   addr_i,
  input  logic [NREQ*DW-1:0]   wdata_i,
  input  logic [NREQ*DW/8-1:0] wmask_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      wr_take_o,
  output logic [DW-1:0]        rd_data_o,
  output logic [NREQ-1:0]      rd_valid_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic                 mem_cmd_o,
  output logic                 mem_cmd_en_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wr_data_o,
  output logic [DW/8-1:0]      mem_data_mask_o,
  input  logic [DW-1:0]        mem_rd_data_i,
  input  logic                 mem_rd_valid_i,
  input  logic                 mem_calib_i
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned PW = cnt_w(NREQ);
  localparam int unsigned BW = cnt_w(BEATS + 1);
  localparam int unsigned GW = cnt_w(GAP);
  localparam int unsigned TW = cnt_w(RD_TIMEOUT);

  state_e          state_q;
  logic [PW-1:0]   w_idx_q, ptr_q;
  logic [BW-1:0]   beat_q;
  logic [GW-1:0]   gap_q;
  logic [TW-1:0]   tmo_q;
  logic [NREQ-1:0] gnt_q, wr_take_q, rd_valid_q, done_q;
  logic [DW-1:0]   rd_data_q, mem_wr_data_q;
  logic [AW-1:0]   mem_addr_q;
  logic [MW-1:0]   mem_mask_q;
  logic            err_q, mem_cmd_q, mem_cmd_en_q;

  logic [NREQ-1:0] pick_oh, w_oh;
  logic [PW-1:0]   pick_idx, ptr_nxt, sel_idx;
  logic [DW-1:0]   wdata_sel;
  logic [MW-1:0]   wmask_sel;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_oh)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_oh[i]) pick_idx = PW'(i);
    end
  end

  assign ptr_nxt   = (pick_idx == PW'(NREQ - 1)) ? PW'(1) : pick_idx + PW'(1);
  assign w_oh      = NREQ'(1) << w_idx_q;
  // Beat 0 comes from the winner being picked; later beats from the latched winner.
  assign sel_idx   = (state_q == StIdle) ? pick_idx : w_idx_q;
  assign wdata_sel = wdata_i[sel_idx*DW +: DW];
  assign wmask_sel = wmask_i[sel_idx*MW +: MW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      w_idx_q       <= '0;
      ptr_q         <= PW'(1);
      beat_q        <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      gnt_q         <= '0;
      wr_take_q     <= '0;
      rd_valid_q    <= '0;
      done_q        <= '0;
      rd_data_q     <= '0;
      mem_wr_data_q <= '0;
      mem_addr_q    <= '0;
      mem_mask_q    <= '0;
      err_q         <= 1'b0;
      mem_cmd_q     <= 1'b0;
      mem_cmd_en_q  <= 1'b0;
    end else begin
      gnt_q        <= '0;
      wr_take_q    <= '0;
      rd_valid_q   <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      mem_cmd_en_q <= 1'b0;
      if (state_q != StIdle && !mem_calib_i) begin
        done_q  <= w_oh;
        err_q   <= 1'b1;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (mem_calib_i && pick_oh != '0) begin
              gnt_q        <= pick_oh;
              mem_cmd_en_q <= 1'b1;
              mem_cmd_q    <= we_i[pick_idx] ? MEM_CMD_WR : MEM_CMD_RD;
              mem_addr_q   <= addr_i[pick_idx*AW +: AW];
              w_idx_q      <= pick_idx;
              tmo_q        <= '0;
              if (pick_idx != '0) ptr_q <= ptr_nxt;
              if (we_i[pick_idx]) begin
                wr_take_q     <= pick_oh;
                mem_wr_data_q <= wdata_sel;
                mem_mask_q    <= wmask_sel;
                beat_q        <= BW'(1);
                state_q       <= StWdata;
              end else begin
                beat_q  <= '0;
                state_q <= StRdwait;
              end
            end
          end
          StWdata: begin
            if (beat_q == BW'(BEATS)) begin
              done_q  <= w_oh;
              gap_q   <= '0;
              state_q <= StGap;
            end else begin
              wr_take_q     <= w_oh;
              mem_wr_data_q <= wdata_sel;
              mem_mask_q    <= wmask_sel;
              beat_q        <= beat_q + BW'(1);
            end
          end
          StRdwait: begin
            tmo_q <= tmo_q + TW'(1);
            if (mem_rd_valid_i) begin
              rd_data_q  <= mem_rd_data_i;
              rd_valid_q <= w_oh;
              beat_q     <= beat_q + BW'(1);
            end
            // A last beat coinciding with the timeout completes cleanly.
            if (mem_rd_valid_i && beat_q == BW'(BEATS - 1)) begin
              done_q  <= w_oh;
              beat_q  <= '0;
              gap_q   <= '0;
              state_q <= StGap;
            end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
              done_q  <= w_oh;
              err_q   <= 1'b1;
              gap_q   <= '0;
              state_q <= StGap;
            end
          end
          StGap: begin
            if (gap_q == GW'(GAP - 1)) state_q <= StIdle;
            else gap_q <= gap_q + GW'(1);
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign gnt_o           = gnt_q;
  assign wr_take_o       = wr_take_q;
  assign rd_valid_o      = rd_valid_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign rd_data_o       = rd_data_q;
  assign mem_cmd_o       = mem_cmd_q;
  assign mem_cmd_en_o    = mem_cmd_en_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wr_data_o   = mem_wr_data_q;
  assign mem_data_mask_o = mem_mask_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: calibration gating, write/read bursts, rotation,
// timeout, calibration loss and reset mid-burst.
module tb_psram_arbiter;

  localparam int unsigned NREQ       = 3;
  localparam int unsigned AW         = 21;
  localparam int unsigned DW         = 32;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned GAP        = 4;
  localparam int unsigned RD_TIMEOUT = 64;
  localparam int unsigned MW         = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req, we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ*MW-1:0]   wmask;
  logic [NREQ-1:0]      gnt, wr_take, rd_valid, done;
  logic [DW-1:0]        rd_data, mem_wr_data, mem_rd_data;
  logic                 err, mem_cmd, mem_cmd_en, mem_rd_valid, mem_calib;
  logic [AW-1:0]        mem_addr;
  logic [MW-1:0]        mem_data_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  psram_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .BEATS(BEATS), .GAP(GAP), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .gnt_o(gnt), .wr_take_o(wr_take), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .done_o(done), .err_o(err), .mem_cmd_o(mem_cmd), .mem_cmd_en_o(mem_cmd_en),
    .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data), .mem_data_mask_o(mem_data_mask),
    .mem_rd_data_i(mem_rd_data), .mem_rd_valid_i(mem_rd_valid), .mem_calib_i(mem_calib)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
    mem_rd_data = '0; mem_rd_valid = 1'b0; mem_calib = 1'b0; rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({gnt, wr_take, rd_valid, done} !== '0) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 0", {gnt, wr_take, rd_valid, done});
    end
    n_cmp++;
    if ({err, mem_cmd, mem_cmd_en} !== 3'b000) begin
      n_bad++; $display("FAIL reset_cmd: got %b want 000", {err, mem_cmd, mem_cmd_en});
    end
    n_cmp++;
    if (mem_addr !== '0 || rd_data !== '0 || mem_wr_data !== '0 || mem_data_mask !== '0) begin
      n_bad++; $display("FAIL reset_data: got addr %h rd %h wd %h m %h want 0",
                        mem_addr, rd_data, mem_wr_data, mem_data_mask);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_calib_gate();
    bit seen = 1'b0;
    int lat = 0;
    req = 3'b111; we = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt !== '0 || mem_cmd_en !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL calib_gate: got a grant want none"); end
    mem_calib = 1'b1;
    while (gnt === '0 && lat < 6) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b001) begin n_bad++; $display("FAIL calib_first_gnt: got %b want 001", gnt); end
    n_cmp++;
    if (lat > 2) begin n_bad++; $display("FAIL calib_gnt_latency: got %0d want <=2", lat); end
    req = '0;
    // Four back-to-back beats starting in the command cycle finish the read.
    for (int t = 0; t < 4; t++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'h5500_0000 + t;
      tick();
    end
    mem_rd_valid = 1'b0;
    n_cmp++;
    if (done !== 3'b001 || err !== 1'b0 || rd_data !== 32'h5500_0003) begin
      n_bad++; $display("FAIL calib_read_done: got done %b err %b rd %h want 001 0 55000003",
                        done, err, rd_data);
    end
    repeat (GAP) tick();
  endtask

  task automatic test_write();
    logic [DW-1:0] a [5];
    int lat = 0;
    a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_1111; a[2] = 32'hA2A2_2222;
    a[3] = 32'hA3A3_3333; a[4] = 32'hDEAD_BEEF;
    req = 3'b010; we = 3'b010;
    addr[AW +: AW] = 21'h01234; wdata[DW +: DW] = a[0]; wmask[MW +: MW] = 4'h5;
    while (gnt === '0 && lat < 12) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b010) begin n_bad++; $display("FAIL wr_gnt: got %b want 010", gnt); end
    n_cmp++;
    if ({mem_cmd_en, mem_cmd} !== 2'b11 || mem_addr !== 21'h01234) begin
      n_bad++; $display("FAIL wr_cmd: got en/cmd %b addr %h want 11 01234",
                        {mem_cmd_en, mem_cmd}, mem_addr);
    end
    req = '0;
    for (int k = 0; k < 4; k++) begin
      logic exp_en;
      exp_en = (k == 0);
      if (k > 0) tick();
      n_cmp++;
      if (wr_take !== 3'b010 || mem_wr_data !== a[k] || mem_data_mask !== 4'h5 ||
          mem_cmd_en !== exp_en) begin
        n_bad++; $display("FAIL wr_beat%0d: got take %b data %h mask %h en %b want 010 %h 5 %b",
                          k, wr_take, mem_wr_data, mem_data_mask, mem_cmd_en, a[k], exp_en);
      end
      wdata[DW +: DW] = a[k+1];
    end
    tick();
    n_cmp++;
    if (done !== 3'b010 || err !== 1'b0 || wr_take !== '0) begin
      n_bad++; $display("FAIL wr_done: got done %b err %b take %b want 010 0 000",
                        done, err, wr_take);
    end
  endtask

  // Entered in the write's done cycle, so the grant latency also measures the gap.
  task automatic test_read();
    logic [DW-1:0] b [4];
    logic [9:0] pat;
    logic [NREQ-1:0] exp_v, exp_d;
    int lat = 0;
    int k = 0;
    int kd = 0;
    int nv = 0;
    b[0] = 32'hB0B0_0000; b[1] = 32'hB1B1_0001; b[2] = 32'hB2B2_0002; b[3] = 32'hB3B3_0003;
    pat = 10'b00_1001_1010;
    req = 3'b100; we = 3'b000; addr[2*AW +: AW] = 21'h1ABCD;
    while (gnt === '0 && lat < 20) begin tick(); lat++; end
    n_cmp++;
    if (lat != GAP + 1) begin n_bad++; $display("FAIL gap_latency: got %0d want %0d", lat, GAP+1); end
    n_cmp++;
    if (gnt !== 3'b100 || mem_cmd !== 1'b0 || mem_cmd_en !== 1'b1 || mem_addr !== 21'h1ABCD) begin
      n_bad++; $display("FAIL rd_cmd: got gnt %b cmd %b en %b addr %h want 100 0 1 1abcd",
                        gnt, mem_cmd, mem_cmd_en, mem_addr);
    end
    req = '0;
    mem_rd_valid = pat[0];
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_v = pat[t-1] ? 3'b100 : 3'b000;
      exp_d = (pat[t-1] && k == 3) ? 3'b100 : 3'b000;
      n_cmp++;
      if (rd_valid !== exp_v || done !== exp_d || err !== 1'b0 ||
          (pat[t-1] && rd_data !== b[k])) begin
        n_bad++; $display("FAIL rd_cycle%0d: got v %b d %b e %b data %h want %b %b 0 %h",
                          t, rd_valid, done, err, rd_data, exp_v, exp_d, b[k]);
      end
      if (rd_valid !== '0) nv++;
      if (pat[t-1]) k++;
      mem_rd_valid = pat[t];
      if (pat[t]) begin mem_rd_data = b[kd]; kd++; end
    end
    mem_rd_valid = 1'b0;
    n_cmp++;
    if (nv != 4) begin n_bad++; $display("FAIL rd_beat_count: got %0d want 4", nv); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp [6];
    exp[0] = 3'b010; exp[1] = 3'b100; exp[2] = 3'b010;
    exp[3] = 3'b001; exp[4] = 3'b100; exp[5] = 3'b010;
    we = 3'b111;
    for (int g = 0; g < 6; g++) begin
      int lat = 0;
      req = (g == 3) ? 3'b111 : 3'b110;
      while (gnt === '0 && lat < 30) begin tick(); lat++; end
      n_cmp++;
      if (gnt !== exp[g]) begin n_bad++; $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, exp[g]); end
      tick();
    end
    req = '0;
    repeat (12) tick();
  endtask

  task automatic test_timeout();
    int lat = 0;
    int nv = 0;
    int done_t = -1;
    logic [NREQ-1:0] done_v = '0;
    logic err_v = 1'b0;
    req = 3'b010; we = 3'b000;
    while (gnt === '0 && lat < 20) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b010) begin n_bad++; $display("FAIL to_gnt: got %b want 010", gnt); end
    req = '0;
    for (int t = 0; t < 68; t++) begin
      if (rd_valid !== '0) nv++;
      if (done !== '0 && done_t < 0) begin done_t = t; done_v = done; err_v = err; end
      mem_rd_valid = (t == 2 || t == 5 || t == 65);
      tick();
    end
    mem_rd_valid = 1'b0;
    n_cmp++;
    if (nv != 2) begin n_bad++; $display("FAIL to_rd_count: got %0d want 2", nv); end
    n_cmp++;
    if (done_t != int'(RD_TIMEOUT)) begin
      n_bad++; $display("FAIL to_cycle: got %0d want %0d", done_t, RD_TIMEOUT);
    end
    n_cmp++;
    if (done_v !== 3'b010 || err_v !== 1'b1) begin
      n_bad++; $display("FAIL to_done_err: got %b %b want 010 1", done_v, err_v);
    end
  endtask

  task automatic test_calib_loss();
    bit seen = 1'b0;
    int lat = 0;
    req = 3'b100; we = 3'b100;
    while (gnt === '0 && lat < 20) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b100 || wr_take !== 3'b100) begin
      n_bad++; $display("FAIL cl_gnt: got gnt %b take %b want 100 100", gnt, wr_take);
    end
    req = '0;
    tick(); tick();
    n_cmp++;
    if (wr_take !== 3'b100) begin n_bad++; $display("FAIL cl_beat2: got %b want 100", wr_take); end
    mem_calib = 1'b0;
    tick();
    n_cmp++;
    if (done !== 3'b100 || err !== 1'b1 || wr_take !== '0) begin
      n_bad++; $display("FAIL cl_abort: got done %b err %b take %b want 100 1 000",
                        done, err, wr_take);
    end
    tick();
    n_cmp++;
    if (done !== '0 || err !== 1'b0 || wr_take !== '0) begin
      n_bad++; $display("FAIL cl_idle: got done %b err %b take %b want 0", done, err, wr_take);
    end
    req = 3'b111; we = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt !== '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL cl_no_gnt: got a grant want none"); end
    mem_calib = 1'b1;
    lat = 0;
    while (gnt === '0 && lat < 6) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b001) begin n_bad++; $display("FAIL cl_regnt: got %b want 001", gnt); end
    req = '0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int lat = 0;
    tick();
    mem_rd_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, wr_take, rd_valid, done, err, mem_cmd_en} !== '0) begin
      n_bad++; $display("FAIL rst_mid_read: got %b want 0",
                        {gnt, wr_take, rd_valid, done, err, mem_cmd_en});
    end
    mem_rd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 3'b010; we = 3'b010;
    while (gnt === '0 && lat < 6) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b010) begin n_bad++; $display("FAIL rst_wr_gnt: got %b want 010", gnt); end
    req = '0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_take, done, err, mem_wr_data} !== '0) begin
      n_bad++; $display("FAIL rst_mid_write: got take %b done %b err %b wd %h want 0",
                        wr_take, done, err, mem_wr_data);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== '0 || err !== 1'b0 || rd_valid !== '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rst_no_done: got a completion pulse want none"); end
    // Pointer must be back at 1 after reset even though it was 2 before.
    req = 3'b110;
    lat = 0;
    while (gnt === '0 && lat < 6) begin tick(); lat++; end
    n_cmp++;
    if (gnt !== 3'b010) begin n_bad++; $display("FAIL rst_ptr: got %b want 010", gnt); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_calib_loss();
    test_reset_mid();
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
